// File: rtl/d_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// d_mem_responder_pkg
// Shared definitions for the multi-cycle data-memory responder:
//   - default data/address width and default access latency
//   - 2-bit FSM state encoding (IDLE=0, BUSY=1, DONE=2; 3 is unused and
//     recovers to IDLE)
//   - helper to size the latency down-counter
// No ports (package).
// ----------------------------------------------------------------------------
package d_mem_responder_pkg;

    localparam int unsigned DmWidth   = 32;
    localparam int unsigned DmAddrW   = 6;
    localparam int unsigned DmLatency = 3;

    typedef enum logic [1:0] {
        DmIdle = 2'd0,
        DmBusy = 2'd1,
        DmDone = 2'd2
    } dm_state_e;

    // Counter width able to hold LATENCY-1; never narrower than one bit.
    function automatic int unsigned dm_cnt_w(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/d_mem_responder_dm_array.sv
// ----------------------------------------------------------------------------
// d_mem_responder_dm_array
// Word array for the data-memory responder. Synchronous write, combinational
// read through a single shared word index. The array is not reset.
// Ports:
//   clk_i    clock, write on rising edge
//   we_i     write enable
//   idx_i    word index (read and write)
//   wdata_i  write data
//   rdata_o  combinational read data of MEMORY[idx_i]
// ----------------------------------------------------------------------------
module d_mem_responder_dm_array #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] MEMORY [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            MEMORY[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = MEMORY[idx_i];

endmodule

// File: rtl/d_mem_responder.sv
// ----------------------------------------------------------------------------
// d_mem_responder
// Memory end of the CPU load/store port. Each request is served after a fixed
// LATENCY cycles; stall_o freezes the pipeline until the access completes.
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   mem_write_i   store request (held while stall_o=1)
//   mem_read_i    load request  (held while stall_o=1)
//   addr_i        byte address
//   write_data_i  store data
//   read_data_o   registered load data, updated only by loads / illegal access
//   stall_o       high while a request is pending and not yet complete
//   err_o         one-cycle pulse in DONE for an illegal access
// ----------------------------------------------------------------------------
module d_mem_responder
    import d_mem_responder_pkg::*;
#(
    parameter int unsigned WIDTH   = DmWidth,
    parameter int unsigned ADDR_W  = DmAddrW,
    parameter int unsigned LATENCY = DmLatency
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_write_i,
    input  logic             mem_read_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] write_data_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             stall_o,
    output logic             err_o
);

    localparam int unsigned CntW = dm_cnt_w(LATENCY);
    localparam logic [CntW-1:0] CntLoad = (LATENCY > 1) ? CntW'(LATENCY - 2) : '0;

    dm_state_e         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              ill_q, ill_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;

    logic              req;
    logic              ill_in;
    logic [ADDR_W-1:0] idx_in;

    // Effective access fields: live inputs while IDLE (needed when LATENCY=1
    // jumps straight to DONE), captured copy otherwise.
    logic              eff_wr;
    logic              eff_ill;
    logic [ADDR_W-1:0] eff_idx;
    logic [WIDTH-1:0]  eff_wdata;
    logic              done_entry;
    logic              arr_we;
    logic [WIDTH-1:0]  arr_rdata;

    assign req    = mem_read_i | mem_write_i;
    assign idx_in = addr_i[ADDR_W+1:2];
    assign ill_in = (addr_i[1:0] != 2'b00)
                  | ((addr_i >> (ADDR_W + 2)) != '0)
                  | (mem_read_i & mem_write_i);

    // Next-state, counter and capture registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        stall_o = 1'b0;
        case (state_q)
            DmIdle: begin
                stall_o = req;
                if (req) begin
                    wr_d    = mem_write_i;
                    ill_d   = ill_in;
                    idx_d   = idx_in;
                    wdata_d = write_data_i;
                    if (LATENCY == 1) begin
                        state_d = DmDone;
                    end else begin
                        cnt_d   = CntLoad;
                        state_d = DmBusy;
                    end
                end
            end
            DmBusy: begin
                stall_o = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DmDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DmDone: begin
                state_d = DmIdle;
            end
            default: begin
                state_d = DmIdle;
            end
        endcase
    end

    always_comb begin
        eff_wr    = (state_q == DmIdle) ? mem_write_i  : wr_q;
        eff_ill   = (state_q == DmIdle) ? ill_in       : ill_q;
        eff_idx   = (state_q == DmIdle) ? idx_in       : idx_q;
        eff_wdata = (state_q == DmIdle) ? write_data_i : wdata_q;
    end

    assign done_entry = (state_d == DmDone);
    // Reset gating keeps an abandoned store from reaching the array.
    assign arr_we     = done_entry & eff_wr & ~eff_ill & ~rst_i;

    always_comb begin
        rdata_d = rdata_q;
        if (done_entry) begin
            if (eff_ill) begin
                rdata_d = '0;
            end else if (!eff_wr) begin
                rdata_d = arr_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DmIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    d_mem_responder_dm_array #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) dm_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .idx_i  (eff_idx),
        .wdata_i(eff_wdata),
        .rdata_o(arr_rdata)
    );

    assign read_data_o = rdata_q;
    assign err_o       = (state_q == DmDone) & ill_q;

    // The CPU must hold its request through BUSY; a drop is only tolerated
    // when it coincides with reset.
    a_req_held_in_busy : assert property (
        @(posedge clk_i) disable iff (rst_i) (state_q == DmBusy) |-> req
    );

endmodule
